// File: rtl/sal_axi_apb_ports.sv
// AXI address and write-response skid buffers with an APB status/scratch register block.
// Each buffer holds two entries in order, with registered ready and valid.
`timescale 1ns/1ps

module sal_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, vld_q;
  logic [W-1:0] e0_q, e1_q;
  logic         push, pop;

  assign push = in_valid_i & rdy_q;
  assign pop  = vld_q & out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  // Ready and valid are both derived from the next occupancy, so neither has a combinational input path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
      vld_q <= (cnt_d != 2'd0);
    end
  end

  // e0 is always the oldest entry; a pop with one held and a push refills e0 directly.
  always_ff @(posedge clk) begin
    if (push && (cnt_q == 2'd0 || pop)) e0_q <= in_data_i;
    else if (pop)                       e0_q <= e1_q;
    if (push && !pop && cnt_q == 2'd1)  e1_q <= in_data_i;
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = vld_q;
  assign out_data_o  = e0_q;
endmodule

module sal_axi_apb_ports #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int PADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_a_valid,
  output logic               s_a_ready,
  input  logic [ID_W-1:0]    s_a_id,
  input  logic [ADDR_W-1:0]  s_a_addr,
  input  logic [7:0]         s_a_len,
  input  logic [2:0]         s_a_size,
  input  logic [1:0]         s_a_burst,
  output logic               m_a_valid,
  input  logic               m_a_ready,
  output logic [ID_W-1:0]    m_a_id,
  output logic [ADDR_W-1:0]  m_a_addr,
  output logic [7:0]         m_a_len,
  output logic [2:0]         m_a_size,
  output logic [1:0]         m_a_burst,
  input  logic               m_b_valid,
  output logic               m_b_ready,
  input  logic [ID_W-1:0]    m_b_id,
  input  logic [1:0]         m_b_resp,
  output logic               s_b_valid,
  input  logic               s_b_ready,
  output logic [ID_W-1:0]    s_b_id,
  output logic [1:0]         s_b_resp,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr
);
  localparam int AW = ID_W + ADDR_W + 13;
  localparam int BW = ID_W + 2;
  localparam logic [PADDR_W-1:0] REG_ID  = PADDR_W'(32'h00);
  localparam logic [PADDR_W-1:0] REG_SCR = PADDR_W'(32'h04);
  localparam logic [PADDR_W-1:0] REG_AC  = PADDR_W'(32'h08);
  localparam logic [PADDR_W-1:0] REG_BC  = PADDR_W'(32'h0C);
  localparam logic [PADDR_W-1:0] REG_ERR = PADDR_W'(32'h10);

  logic [AW-1:0] a_in, a_out;
  logic [BW-1:0] b_in, b_out;

  assign a_in = {s_a_id, s_a_addr, s_a_len, s_a_size, s_a_burst};
  assign {m_a_id, m_a_addr, m_a_len, m_a_size, m_a_burst} = a_out;
  assign b_in = {m_b_id, m_b_resp};
  assign {s_b_id, s_b_resp} = b_out;

  sal_skid2 #(.W(AW)) u_a_buf (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(s_a_valid), .in_ready_o(s_a_ready), .in_data_i(a_in),
    .out_valid_o(m_a_valid), .out_ready_i(m_a_ready), .out_data_o(a_out)
  );

  sal_skid2 #(.W(BW)) u_b_buf (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(m_b_valid), .in_ready_o(m_b_ready), .in_data_i(b_in),
    .out_valid_o(s_b_valid), .out_ready_i(s_b_ready), .out_data_o(b_out)
  );

  logic [31:0] scr_q, scr_d, acnt_q, acnt_d, bcnt_q, bcnt_d;
  logic [1:0]  err_q, err_d, err_set, err_clr;
  logic        access, rd_err, wr_en;
  logic [31:0] rd_data;

  assign access = psel & penable;

  always_comb begin
    rd_data = 32'd0;
    rd_err  = 1'b0;
    if (access) begin
      case (paddr)
        REG_ID:  rd_data = 32'h5341_0001;
        REG_SCR: rd_data = scr_q;
        REG_AC:  rd_data = acnt_q;
        REG_BC:  rd_data = bcnt_q;
        REG_ERR: rd_data = {30'd0, err_q};
        default: rd_err  = 1'b1;
      endcase
    end
  end

  assign prdata  = rd_data;
  assign pslverr = rd_err;
  assign pready  = 1'b1;
  assign wr_en   = access & pwrite & ~rd_err;

  always_comb begin
    scr_d   = (wr_en && paddr == REG_SCR) ? pwdata : scr_q;
    acnt_d  = (m_a_valid && m_a_ready) ? acnt_q + 32'd1 : acnt_q;
    bcnt_d  = (s_b_valid && s_b_ready) ? bcnt_q + 32'd1 : bcnt_q;
    err_set = {s_a_valid && s_a_ready && s_a_burst == 2'b11,
               s_b_valid && s_b_ready && s_b_resp != 2'b00};
    err_clr = (wr_en && paddr == REG_ERR) ? pwdata[1:0] : 2'b00;
    // Set is OR-ed in after the clear so a coincident event is never lost.
    err_d   = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scr_q  <= 32'd0;
      acnt_q <= 32'd0;
      bcnt_q <= 32'd0;
      err_q  <= 2'b00;
    end else begin
      scr_q  <= scr_d;
      acnt_q <= acnt_d;
      bcnt_q <= bcnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_sal_axi_apb_ports.sv
// Bench for sal_axi_apb_ports: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps

module tb_sal_axi_apb_ports;
  localparam int ID_W = 4, ADDR_W = 32, PADDR_W = 12;
  localparam int AW = ID_W + ADDR_W + 13;
  localparam int BW = ID_W + 2;

  logic clk, rst_n;
  logic s_a_valid, s_a_ready, m_a_valid, m_a_ready;
  logic [ID_W-1:0] s_a_id, m_a_id, m_b_id, s_b_id;
  logic [ADDR_W-1:0] s_a_addr, m_a_addr;
  logic [7:0] s_a_len, m_a_len;
  logic [2:0] s_a_size, m_a_size;
  logic [1:0] s_a_burst, m_a_burst, m_b_resp, s_b_resp;
  logic m_b_valid, m_b_ready, s_b_valid, s_b_ready;
  logic psel, penable, pwrite, pready, pslverr;
  logic [PADDR_W-1:0] paddr;
  logic [31:0] pwdata, prdata;

  sal_axi_apb_ports #(.ID_W(ID_W), .ADDR_W(ADDR_W), .PADDR_W(PADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_id(s_a_id), .s_a_addr(s_a_addr),
    .s_a_len(s_a_len), .s_a_size(s_a_size), .s_a_burst(s_a_burst),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_id(m_a_id), .m_a_addr(m_a_addr),
    .m_a_len(m_a_len), .m_a_size(m_a_size), .m_a_burst(m_a_burst),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO queues for the buffers plus plain register copies.
  logic [AW-1:0] aq[$];
  logic [BW-1:0] bq[$];
  bit          m_sar, m_mbr, axi_rand;
  logic [31:0] m_scr, m_acnt, m_bcnt;
  logic [1:0]  m_err;
  int checks, fails;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] mread(input logic [PADDR_W-1:0] a);
    if (a[1:0] != 2'b00) return {1'b1, 32'd0};
    case (a)
      12'h000: return {1'b0, 32'h5341_0001};
      12'h004: return {1'b0, m_scr};
      12'h008: return {1'b0, m_acnt};
      12'h00C: return {1'b0, m_bcnt};
      12'h010: return {1'b0, 30'd0, m_err};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic rand_axi();
    s_a_valid = 1'($urandom_range(0, 1));
    s_a_id    = ID_W'($urandom);
    s_a_addr  = ADDR_W'($urandom);
    s_a_len   = 8'($urandom);
    s_a_size  = 3'($urandom);
    s_a_burst = 2'($urandom);
    m_a_ready = 1'($urandom_range(0, 1));
    m_b_valid = 1'($urandom_range(0, 1));
    m_b_id    = ID_W'($urandom);
    m_b_resp  = 2'($urandom);
    s_b_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    bit push_a, pop_a, push_b, pop_b;
    logic [AW-1:0] ain;
    logic [BW-1:0] bin;
    logic [1:0] set, clr;
    logic [31:0] new_scr;
    if (axi_rand) rand_axi();
    push_a = s_a_valid && m_sar;
    pop_a  = (aq.size() > 0) && m_a_ready;
    push_b = m_b_valid && m_mbr;
    pop_b  = (bq.size() > 0) && s_b_ready;
    ain = {s_a_id, s_a_addr, s_a_len, s_a_size, s_a_burst};
    bin = {m_b_id, m_b_resp};
    set = {push_a && s_a_burst == 2'b11, pop_b && bq[0][1:0] != 2'b00};
    clr = (psel && penable && pwrite && paddr == 12'h010) ? pwdata[1:0] : 2'b00;
    new_scr = (psel && penable && pwrite && paddr == 12'h004) ? pwdata : m_scr;
    @(posedge clk);
    if (!rst_n) begin
      aq.delete(); bq.delete();
      m_sar = 0; m_mbr = 0;
      m_scr = 0; m_acnt = 0; m_bcnt = 0; m_err = 0;
    end else begin
      if (pop_a) begin void'(aq.pop_front()); m_acnt = m_acnt + 32'd1; end
      if (push_a) aq.push_back(ain);
      if (pop_b) begin void'(bq.pop_front()); m_bcnt = m_bcnt + 32'd1; end
      if (push_b) bq.push_back(bin);
      m_err = (m_err & ~clr) | set;
      m_scr = new_scr;
      m_sar = aq.size() < 2;
      m_mbr = bq.size() < 2;
    end
    #1;
    chk("s_a_ready", 64'(s_a_ready), 64'(m_sar));
    chk("m_b_ready", 64'(m_b_ready), 64'(m_mbr));
    chk("m_a_valid", 64'(m_a_valid), 64'(aq.size() > 0));
    chk("s_b_valid", 64'(s_b_valid), 64'(bq.size() > 0));
    if (aq.size() > 0)
      chk("m_a_payload", 64'({m_a_id, m_a_addr, m_a_len, m_a_size, m_a_burst}), 64'(aq[0]));
    if (bq.size() > 0)
      chk("s_b_payload", 64'({s_b_id, s_b_resp}), 64'(bq[0]));
  endtask

  task automatic apb_read(input logic [PADDR_W-1:0] a, output logic [31:0] rd);
    logic [32:0] exp;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    #1;
    chk("apb_setup_prdata", 64'(prdata), 64'd0);
    chk("apb_setup_pslverr", 64'(pslverr), 64'd0);
    step();
    penable = 1;
    #1;
    exp = mread(a);
    rd = prdata;
    chk("apb_prdata", 64'(prdata), 64'(exp[31:0]));
    chk("apb_pslverr", 64'(pslverr), 64'(exp[32]));
    chk("apb_pready", 64'(pready), 64'd1);
    step();
    psel = 0; penable = 0;
  endtask

  task automatic apb_write(input logic [PADDR_W-1:0] a, input logic [31:0] d);
    logic [32:0] exp;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    step();
    penable = 1;
    #1;
    exp = mread(a);
    chk("apb_wr_pslverr", 64'(pslverr), 64'(exp[32]));
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic axi_idle();
    s_a_valid = 0; m_a_ready = 0; m_b_valid = 0; s_b_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  function automatic logic [PADDR_W-1:0] pick_addr();
    logic [PADDR_W-1:0] tbl[8];
    tbl = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h006, 12'h000};
    tbl[7] = PADDR_W'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  logic [31:0] rd;

  initial begin
    checks = 0; fails = 0; axi_rand = 0;
    m_sar = 0; m_mbr = 0; m_scr = 0; m_acnt = 0; m_bcnt = 0; m_err = 0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    s_a_id = '0; s_a_addr = '0; s_a_len = '0; s_a_size = '0; s_a_burst = '0;
    m_b_id = '0; m_b_resp = '0;
    axi_idle();
    rst_n = 0;
    step(); step();
    chk("reset_s_a_ready", 64'(s_a_ready), 64'd0);
    chk("reset_m_a_valid", 64'(m_a_valid), 64'd0);
    rst_n = 1;
    step();
    chk("post_reset_s_a_ready", 64'(s_a_ready), 64'd1);

    // Single beat with an immediately ready downstream.
    s_a_valid = 1; s_a_id = 0; s_a_addr = 32'h0000_2000; s_a_len = 1; s_a_size = 3'd4;
    s_a_burst = 2'b01; m_a_ready = 1;
    step();
    chk("single_beat_valid", 64'(m_a_valid), 64'd1);
    chk("single_beat_addr", 64'(m_a_addr), 64'h2000);
    s_a_valid = 0;
    step();
    apb_read(12'h008, rd);
    chk("a_cnt_one", 64'(rd), 64'd1);

    // Back-pressure: third beat must stall, then all drain in order.
    m_a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      s_a_valid = 1; s_a_addr = 32'h100 + i; s_a_id = ID_W'(i);
      step();
    end
    chk("full_stall", 64'(s_a_ready), 64'd0);
    s_a_valid = 0; m_a_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // Sustained throughput of one beat per cycle.
    axi_idle();
    do_reset();
    m_a_ready = 1;
    for (int i = 0; i < 16; i++) begin
      s_a_valid = 1; s_a_addr = ADDR_W'($urandom); s_a_burst = 2'b01;
      step();
    end
    s_a_valid = 0;
    step();
    apb_read(12'h008, rd);
    chk("a_cnt_sixteen", 64'(rd), 64'd16);

    // Write responses, error capture and clear.
    axi_idle();
    s_b_ready = 1;
    m_b_valid = 1; m_b_id = 0; m_b_resp = 2'b00;
    step();
    m_b_resp = 2'b10;
    step();
    m_b_valid = 0;
    for (int i = 0; i < 3; i++) step();
    apb_read(12'h010, rd);
    chk("err_set", 64'(rd), 64'd1);
    apb_write(12'h010, 32'h1);
    apb_read(12'h010, rd);
    chk("err_cleared", 64'(rd), 64'd0);

    // Register map.
    apb_write(12'h004, 32'hDEAD_BEEF);
    apb_read(12'h004, rd);
    chk("scratch_rd", 64'(rd), 64'hDEAD_BEEF);
    apb_read(12'h000, rd);
    chk("id_rd", 64'(rd), 64'h5341_0001);
    apb_read(12'h014, rd);
    apb_write(12'h000, 32'h1234);
    apb_write(12'h00E, 32'h5555);

    // Reset while holding two entries.
    axi_idle();
    s_a_valid = 1;
    step(); step();
    s_a_valid = 0;
    rst_n = 0;
    step();
    chk("midrst_m_a_valid", 64'(m_a_valid), 64'd0);
    chk("midrst_s_a_ready", 64'(s_a_ready), 64'd0);
    rst_n = 1;
    step();
    apb_read(12'h008, rd);
    chk("midrst_a_cnt", 64'(rd), 64'd0);
    apb_read(12'h004, rd);

    // Random traffic with interleaved register accesses.
    axi_rand = 1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      case ($urandom_range(0, 9))
        0: apb_read(pick_addr(), rd);
        1: apb_write(pick_addr(), $urandom);
        2: apb_write(12'h010, $urandom);
        default: step();
      endcase
    end
    axi_rand = 0;
    apb_read(12'h008, rd);
    apb_read(12'h00C, rd);
    apb_read(12'h010, rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sal_axi_apb_ports.md
SAL_AXI_APB_PORTS -- requirements
Module: sal_axi_apb_ports

Interface
REQ-001 Parameter ID_W, default 4: AXI ID width.
REQ-002 Parameter ADDR_W, default 32: AXI address width.
REQ-003 Parameter PADDR_W, default 12: APB address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 s_a_valid  in  1, s_a_ready  out  1: upstream AXI address (AW/AR) handshake.
REQ-007 s_a_id, s_a_addr, s_a_len, s_a_size, s_a_burst  in  ID_W, ADDR_W, 8, 3, 2  upstream address payload.
REQ-008 m_a_valid  out  1, m_a_ready  in  1: downstream address handshake.
REQ-009 m_a_id, m_a_addr, m_a_len, m_a_size, m_a_burst  out  same widths as REQ-007  downstream address payload.
REQ-010 m_b_valid  in  1, m_b_ready  out  1, m_b_id  in  ID_W, m_b_resp  in  2: downstream write-response side.
REQ-011 s_b_valid  out  1, s_b_ready  in  1, s_b_id  out  ID_W, s_b_resp  out  2: upstream write-response side.
REQ-012 psel, penable, pwrite  in  1 each; paddr  in  PADDR_W; pwdata  in  32: APB requester signals.
REQ-013 prdata  out  32, pready  out  1, pslverr  out  1: APB completer signals.

Function
REQ-014 A path SHALL be a 2-entry in-order skid buffer carrying {id, addr, len, size, burst} unmodified from s_a to m_a.
REQ-015 s_a_ready SHALL be a register: 1 when fewer than 2 entries held after the current edge, else 0; no combinational path m_a_ready -> s_a_ready.
REQ-016 m_a_valid SHALL be registered, 1 whenever at least 1 entry held; m_a payload SHALL be the oldest entry and stay stable while m_a_valid=1 and m_a_ready=0.
REQ-017 Handshake occurs when valid=1 and ready=1 on a rising edge; simultaneous push and pop with 1 entry held SHALL keep 1 entry (new payload), sustaining 1 transfer/cycle.
REQ-018 Empty-to-valid latency: a beat accepted at edge N SHALL appear on m_a at edge N+1 (1 cycle).
REQ-019 B path SHALL be an identical 2-entry skid buffer carrying {id, resp} from m_b to s_b, same ready/valid/latency rules (m_b_ready registered).
REQ-020 APB SHALL be zero-wait: pready=1 always.
REQ-021 Access phase = psel=1 and penable=1; writes commit at that edge; prdata and pslverr SHALL be valid combinationally during the access phase, else prdata=0 and pslverr=0.
REQ-022 Register map (32-bit, word-aligned): 0x00 ID RO = 32'h5341_0001; 0x04 SCRATCH RW, reset 0; 0x08 A_CNT RO; 0x0C B_CNT RO; 0x10 ERR W1C.
REQ-023 A_CNT SHALL increment by 1 per m_a handshake, B_CNT by 1 per s_b handshake; both wrap from 32'hFFFF_FFFF to 0.
REQ-024 ERR bit0 SHALL set on any s_b handshake with resp != 2'b00; bit1 SHALL set on any s_a handshake with burst == 2'b11; bits [31:2] read 0.
REQ-025 Writing 1 to an ERR bit SHALL clear it; if set and clear coincide in one cycle, set SHALL win.
REQ-026 Write to RO register SHALL be ignored with pslverr=0; any unmapped or non-word-aligned paddr SHALL give pslverr=1, prdata=0, no state change.
REQ-027 Payload fields SHALL never be checked or altered beyond REQ-024; len/size/burst pass through verbatim.

Reset
REQ-028 While rst_n=0 at an edge: both buffers emptied, s_a_ready=0, m_b_ready=0, m_a_valid=0, s_b_valid=0, SCRATCH/A_CNT/B_CNT/ERR=0.
REQ-029 First edge with rst_n=1 SHALL set s_a_ready=1 and m_b_ready=1; reset asserted mid-transfer SHALL drop all held entries without output handshake.
REQ-030 Payload registers need no reset; their outputs are don't-care while the matching valid=0.

Verification
REQ-031 After reset, push id=0, addr=32'h0000_2000, len=1, size=3'd4, burst=2'b01 with m_a_ready=1 -> m_a_valid=1 next cycle with identical payload; A_CNT reads 1.
REQ-032 m_a_ready=0, push 3 beats back-to-back -> first 2 accepted, s_a_ready=0 on 3rd; release m_a_ready -> beats exit in order, no loss or duplicate.
REQ-033 Continuous s_a_valid and m_a_ready=1 for 16 cycles -> 16 handshakes on each side, A_CNT=16.
REQ-034 m_b drives id=0 resp=2'b00 then resp=2'b10 -> s_b delivers both in order; ERR reads 1; write 1 to 0x10 -> ERR reads 0.
REQ-035 APB write 32'hDEAD_BEEF to 0x04 then read -> prdata=32'hDEAD_BEEF, pslverr=0; read 0x00 -> 32'h5341_0001; read 0x14 -> pslverr=1, prdata=0.
REQ-036 Assert rst_n=0 with 2 A entries held -> m_a_valid=0, s_a_ready=0 next edge; counters read 0 after release.
